// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency synchronous memory
// between the instruction-fetch port and the load/store port.
//
// Parameters:
//   XLEN          data word width (32)
//   ADDR_WIDTH    word-address width
//   MEM_LATENCY   cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_LIMIT  max back-to-back data grants while a fetch waits (1..15)
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_req/i_addr            fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata  fetch accept, response pulse, instruction
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata  data accept, response pulse, load data (0 on store)
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory request strobe and fields
//   mem_rdata               memory read data, MEM_LATENCY cycles after mem_en
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let a waiting fetch win
// after STARVE_LIMIT consecutive data grants. Undefined = strict data priority.

module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [XLEN/8-1:0]     d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [XLEN-1:0]       d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [XLEN-1:0]       d_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("MEM_LATENCY out of range 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("STARVE_LIMIT out of range 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       store_q, store_d;

    logic       resp;
    logic       free;
    logic       pick_d;
    logic       pick_i;
    logic       starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
    // Counts data grants that jumped a waiting fetch; a fetch grant or a
    // cycle without a fetch request ends the run.
    logic [3:0] starve_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else if (!i_req || pick_i) begin
            starve_q <= 4'd0;
        end else if (pick_d && starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
        end
    end

    assign starve_hit = (starve_q == 4'(STARVE_LIMIT));
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
        end
    end

    // The response cycle doubles as an idle cycle so a new grant can be
    // issued alongside rvalid, giving one access per MEM_LATENCY cycles.
    always_comb begin
        resp   = (state_q != IDLE) && (cnt_q == 4'd0);
        free   = (state_q == IDLE) || resp;
        pick_d = free && d_req && !(i_req && starve_hit);
        pick_i = free && i_req && !pick_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        store_d   = store_q;

        i_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Outputs are forced quiet during reset even though the
        // registered state only clears at the edge.
        if (!reset) begin
            if (state_q != IDLE && cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end

            if (resp) begin
                state_d = IDLE;
                if (state_q == BUSY_I) begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata[31:0];
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = store_q ? '0 : mem_rdata;
                end
            end

            unique case (1'b1)
                pick_d: begin
                    d_gnt     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = d_we;
                    mem_be    = d_be;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    state_d   = BUSY_D;
                    cnt_d     = CNT_INIT;
                    store_d   = d_we;
                end
                pick_i: begin
                    i_gnt    = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = i_addr;
                    state_d  = BUSY_I;
                    cnt_d    = CNT_INIT;
                    store_d  = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// latency-2 main instance plus latency-1 and latency-3 fetch-stream instances.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        s1_i_req, s3_i_req;
    logic [7:0]  s1_i_addr, s3_i_addr;
    logic        s1_i_gnt, s1_i_rvalid, s3_i_gnt, s3_i_rvalid;
    logic [31:0] s1_i_rdata, s3_i_rdata;
    logic        s1_d_gnt, s1_d_rvalid, s3_d_gnt, s3_d_rvalid;
    logic [31:0] s1_d_rdata, s3_d_rdata;
    logic        s1_mem_en, s1_mem_we, s3_mem_en, s3_mem_we;
    logic [3:0]  s1_mem_be, s3_mem_be;
    logic [7:0]  s1_mem_addr, s3_mem_addr;
    logic [31:0] s1_mem_wdata, s3_mem_wdata;
    logic [31:0] s1_mem_rdata, s3_mem_rdata;

    logic        tie0 = 1'b0;
    logic [3:0]  tie_be = 4'h0;
    logic [7:0]  tie_addr = 8'h00;
    logic [31:0] tie_data = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .i_req(s1_i_req), .i_addr(s1_i_addr), .i_gnt(s1_i_gnt),
        .i_rvalid(s1_i_rvalid), .i_rdata(s1_i_rdata),
        .d_req(tie0), .d_we(tie0), .d_be(tie_be), .d_addr(tie_addr),
        .d_wdata(tie_data), .d_gnt(s1_d_gnt), .d_rvalid(s1_d_rvalid),
        .d_rdata(s1_d_rdata),
        .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_be(s1_mem_be),
        .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata),
        .mem_rdata(s1_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .i_req(s3_i_req), .i_addr(s3_i_addr), .i_gnt(s3_i_gnt),
        .i_rvalid(s3_i_rvalid), .i_rdata(s3_i_rdata),
        .d_req(tie0), .d_we(tie0), .d_be(tie_be), .d_addr(tie_addr),
        .d_wdata(tie_data), .d_gnt(s3_d_gnt), .d_rvalid(s3_d_rvalid),
        .d_rdata(s3_d_rdata),
        .mem_en(s3_mem_en), .mem_we(s3_mem_we), .mem_be(s3_mem_be),
        .mem_addr(s3_mem_addr), .mem_wdata(s3_mem_wdata),
        .mem_rdata(s3_mem_rdata)
    );

    // Main memory: 256 words, 2-cycle read pipe; store slots return all-ones
    // so a store ack that leaks mem_rdata is visible.
    logic [31:0] mem [256];
    logic [31:0] p0 = 32'h0, p1 = 32'h0;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        p0 <= mem_en ? (mem_we ? 32'hFFFF_FFFF : mem[mem_addr]) : 32'h0;
        p1 <= p0;
    end
    assign mem_rdata = p1;

    // Stream memories return a tag of the address.
    logic [31:0] q1 = 32'h0, q3a = 32'h0, q3b = 32'h0, q3c = 32'h0;
    always @(posedge clk) begin
        q1  <= {8'hA5, 16'h0, s1_mem_addr};
        q3a <= {8'hA5, 16'h0, s3_mem_addr};
        q3b <= q3a;
        q3c <= q3b;
    end
    assign s1_mem_rdata = q1;
    assign s3_mem_rdata = q3c;

    task automatic idle_inputs();
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        s1_i_req = 0; s1_i_addr = 0;
        s3_i_req = 0; s3_i_addr = 0;
    endtask

    task automatic test_reset();
        logic [5:0]  ctl;
        logic [83:0] dat;
        reset = 1;
        idle_inputs();
        i_req = 1; d_req = 1; i_addr = 8'h04; d_addr = 8'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            ctl = {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we};
            dat = {i_rdata, d_rdata[19:0], mem_addr, mem_be, mem_wdata[19:0]};
            checks++;
            if (ctl !== 6'h0 || dat !== 84'h0) begin
                errors++;
                $display("FAIL reset_outputs ctl=%b dat=%h want 0", ctl, dat);
            end
        end
        @(negedge clk);
        idle_inputs();
        reset = 0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset mem_en=%b i_gnt=%b want 0", mem_en, i_gnt);
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_req = 1; i_addr = 8'h04; #1;
        checks++;
        if ({i_gnt, mem_en, mem_we, d_gnt, mem_addr} !== {4'b1100, 8'h04}) begin
            errors++;
            $display("FAIL fetch_grant got %b%b%b%b addr %h want 1100 04",
                     i_gnt, mem_en, mem_we, d_gnt, mem_addr);
        end
        @(negedge clk);
        i_req = 0; #1;
        checks++;
        if (i_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait rvalid=%b mem_en=%b want 0", i_rvalid, mem_en);
        end
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp rvalid=%b rdata=%h d_rvalid=%b want 1 00500093 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_pulse rvalid=%b rdata=%h want 0 0", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        i_req = 1; i_addr = 8'h08;
        d_req = 1; d_we = 0; d_addr = 8'h10; #1;
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL coll_grant d_gnt=%b i_gnt=%b addr=%h want 1 0 10",
                     d_gnt, i_gnt, mem_addr);
        end
        @(negedge clk);
        d_req = 0; #1;
        checks++;
        if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL coll_busy d_gnt=%b i_gnt=%b want 0 0", d_gnt, i_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_gnt !== 1'b1 ||
            mem_addr !== 8'h08 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL coll_resp d_rv=%b d_rdata=%h i_gnt=%b addr=%h i_rv=%b want 1 deadbeef 1 08 0",
                     d_rvalid, d_rdata, i_gnt, mem_addr, i_rvalid);
        end
        @(negedge clk);
        i_req = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h11111111 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL coll_fetch i_rv=%b i_rdata=%h d_rv=%b want 1 11111111 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        d_req = 1; d_we = 1; d_be = 4'b0011;
        d_addr = 8'h20; d_wdata = 32'h12345678; #1;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
            mem_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_grant gnt=%b we=%b be=%b wdata=%h want 1 1 0011 12345678",
                     d_gnt, mem_we, mem_be, mem_wdata);
        end
        @(negedge clk);
        d_req = 0; d_we = 0; d_be = 0; d_wdata = 0; #1;
        @(negedge clk);
        d_req = 1; d_addr = 8'h20; #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL store_ack rv=%b rdata=%h gnt=%b we=%b want 1 0 1 0",
                     d_rvalid, d_rdata, d_gnt, mem_we);
        end
        @(negedge clk);
        d_req = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h00005678) begin
            errors++;
            $display("FAIL load_back rv=%b rdata=%h want 1 00005678", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic        g1, v1, g3, v3;
        logic [31:0] r1, r3;
        logic [7:0]  t;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            s1_i_req = (c <= 3); s1_i_addr = 8'(c);
            s3_i_req = (c <= 9); s3_i_addr = 8'(c / 3);
            #1;
            g1 = (c < 4);
            v1 = (c >= 1 && c <= 4);
            t  = 8'(c - 1);
            r1 = v1 ? {8'hA5, 16'h0, t} : 32'h0;
            g3 = (c % 3 == 0) && (c <= 9);
            v3 = (c % 3 == 0) && (c >= 3);
            t  = 8'(c / 3 - 1);
            r3 = v3 ? {8'hA5, 16'h0, t} : 32'h0;
            checks++;
            if (s1_i_gnt !== g1 || s1_i_rvalid !== v1 || s1_i_rdata !== r1 ||
                s1_d_rvalid !== 1'b0 || s1_d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL stream_l1 c=%0d gnt=%b rv=%b rdata=%h d_rv=%b want %b %b %h 0",
                         c, s1_i_gnt, s1_i_rvalid, s1_i_rdata, s1_d_rvalid, g1, v1, r1);
            end
            checks++;
            if (s3_i_gnt !== g3 || s3_i_rvalid !== v3 || s3_i_rdata !== r3 ||
                s3_d_rvalid !== 1'b0 || s3_d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL stream_l3 c=%0d gnt=%b rv=%b rdata=%h d_rv=%b want %b %b %h 0",
                         c, s3_i_gnt, s3_i_rvalid, s3_i_rdata, s3_d_rvalid, g3, v3, r3);
            end
        end
        @(negedge clk);
        s1_i_req = 0; s3_i_req = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 8'h10; #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant d_gnt=%b want 1", d_gnt);
        end
        @(negedge clk);
        d_req = 0; reset = 1; i_req = 1; i_addr = 8'h04; #1;
        checks++;
        if ({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'h0 ||
            {i_rdata, d_rdata, mem_addr, mem_be, mem_wdata} !== 108'h0) begin
            errors++;
            $display("FAIL rmid_outputs i_gnt=%b d_gnt=%b mem_en=%b addr=%h want 0",
                     i_gnt, d_gnt, mem_en, mem_addr);
        end
        @(negedge clk);
        reset = 0; #1;
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmid_drop d_rv=%b d_rdata=%h i_gnt=%b want 0 0 1",
                     d_rvalid, d_rdata, i_gnt);
        end
        @(negedge clk);
        i_req = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_fresh rv=%b rdata=%h d_rv=%b want 1 00500093 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic guard;
        logic exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 8'h10;
        i_req = 1; i_addr = 8'h08;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_i = guard && (k % 5 == 4);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || (i_rvalid && d_rvalid)) begin
                errors++;
                $display("FAIL starve k=%0d i_gnt=%b d_gnt=%b overlap=%b want %b %b 0",
                         k, i_gnt, d_gnt, i_rvalid && d_rvalid, exp_i, !exp_i);
            end
            @(negedge clk); #1;
            checks++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL starve_gap k=%0d i_gnt=%b d_gnt=%b want 0 0",
                         k, i_gnt, d_gnt);
            end
            @(negedge clk);
        end
        i_req = 0; d_req = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h00500093;
        mem[8'h08] = 32'h11111111;
        mem[8'h10] = 32'hDEADBEEF;

        test_reset();
        test_single_fetch();
        test_collision();
        test_store_load();
        test_back_to_back();
        test_reset_mid();
        test_starvation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
